// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: data/instruction stalls, load-use interlock and redirect flush.
// Define HAZARD_FWD_EN to enable operand forwarding and the one-cycle load-use stall.
module pipe_hazard_ctrl #(
    parameter int NLATCH = 4,
    parameter int CNTW   = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              dmem_req,
    input  logic              redirect,
    input  logic [4:0]        id_rsel1,
    input  logic [4:0]        id_rsel2,
    input  logic [4:0]        ex_wsel,
    input  logic [4:0]        mem_wsel,
    input  logic              ex_regwr,
    input  logic              mem_regwr,
    input  logic              ex_is_load,
    output logic              pc_en,
    output logic [NLATCH-1:0] stage_en,
    output logic [NLATCH-1:0] stage_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNTW-1:0]   stall_cnt,
    output logic [CNTW-1:0]   flush_cnt
);

    typedef enum logic [1:0] {RUN, DSTALL, LUSTALL, FLUSH} state_t;

    state_t state_q, state_d;
    logic   redir_pend_q;

    logic raw_ex_a, raw_ex_b, raw_mem_a, raw_mem_b;
    logic raw_ex, raw_mem, lu;
    logic dstall_c, flush_c, lustall_c;
    logic is_dstall, is_flush, is_lustall, is_imiss;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + {{(CNTW-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit,
                                           input logic ex_load);
        if (ex_hit)
            return ex_load ? 2'b00 : 2'b01;
        else if (mem_hit)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        raw_ex_a  = ex_regwr  && (ex_wsel  != 5'd0) && (ex_wsel  == id_rsel1);
        raw_ex_b  = ex_regwr  && (ex_wsel  != 5'd0) && (ex_wsel  == id_rsel2);
        raw_mem_a = mem_regwr && (mem_wsel != 5'd0) && (mem_wsel == id_rsel1);
        raw_mem_b = mem_regwr && (mem_wsel != 5'd0) && (mem_wsel == id_rsel2);
        raw_ex    = raw_ex_a | raw_ex_b;
        raw_mem   = raw_mem_a | raw_mem_b;
        lu        = raw_ex & ex_is_load;
        dstall_c  = dmem_req & ~dhit;
        // A redirect that arrived during a data stall is still owed here.
        flush_c   = redirect | redir_pend_q;
`ifdef HAZARD_FWD_EN
        lustall_c = lu && (state_q != LUSTALL);
`else
        lustall_c = raw_ex | raw_mem | lu;
`endif
    end

    always_comb begin
        is_dstall  = 1'b0;
        is_flush   = 1'b0;
        is_lustall = 1'b0;
        is_imiss   = 1'b0;
        if (dstall_c)
            is_dstall = 1'b1;
        else if (flush_c)
            is_flush = 1'b1;
        else if (lustall_c)
            is_lustall = 1'b1;
        else if (!ihit)
            is_imiss = 1'b1;
    end

    always_comb begin
        state_d = RUN;
        if (is_dstall)
            state_d = DSTALL;
        else if (is_flush)
            state_d = FLUSH;
        else if (is_lustall)
            state_d = LUSTALL;
        else if (is_imiss)
            state_d = state_q;
    end

    always_comb begin
        pc_en       = ihit;
        stage_en    = '1;
        stage_flush = '0;
        if (is_dstall) begin
            pc_en    = 1'b0;
            stage_en = '0;
        end else if (is_flush) begin
            pc_en            = 1'b1;
            stage_flush[1:0] = 2'b11;
        end else if (is_lustall) begin
            pc_en          = 1'b0;
            stage_en[0]    = 1'b0;
            stage_flush[1] = 1'b1;
        end else if (is_imiss) begin
            pc_en          = 1'b0;
            stage_flush[0] = 1'b1;
        end
        if (!nRST) begin
            pc_en       = 1'b0;
            stage_en    = '0;
            stage_flush = '1;
        end
    end

    always_comb begin
`ifdef HAZARD_FWD_EN
        fwd_a = fwd_sel(raw_ex_a, raw_mem_a, ex_is_load);
        fwd_b = fwd_sel(raw_ex_b, raw_mem_b, ex_is_load);
`else
        fwd_a = 2'b00;
        fwd_b = 2'b00;
`endif
        if (!nRST) begin
            fwd_a = 2'b00;
            fwd_b = 2'b00;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= RUN;
            redir_pend_q <= 1'b0;
            stall_cnt    <= '0;
            flush_cnt    <= '0;
        end else begin
            state_q      <= state_d;
            redir_pend_q <= is_dstall & flush_c;
            if (is_dstall | is_lustall)
                stall_cnt <= sat_inc(stall_cnt);
            if (is_flush)
                flush_cnt <= sat_inc(flush_cnt);
        end
    end

endmodule
